// File: rtl/ex_cond_stage.sv
// Decode-to-execute pipeline register with NZCV flags and ARM condition evaluation.
// Gated E-stage controls are qualified by the condition result of the instruction in E.
module ex_cond_stage #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic       PCSrcD,
  input  logic       RegWriteD,
  input  logic       MemtoRegD,
  input  logic       MemWriteD,
  input  logic [3:0] ALUControlD,
  input  logic       BranchD,
  input  logic       ALUSrcD,
  input  logic [1:0] FlagWriteD,
  input  logic [3:0] CondD,
  input  logic [3:0] ALUFlagsE,
  output logic       PCSrcE,
  output logic       RegWriteE,
  output logic       MemWriteE,
  output logic       BranchTakenE,
  output logic       MemtoRegE,
  output logic [3:0] ALUControlE,
  output logic       ALUSrcE,
  output logic       CondExE,
  output logic [3:0] FlagsE
);

  logic       pcSrcQ;
  logic       regWriteQ;
  logic       memtoRegQ;
  logic       memWriteQ;
  logic [3:0] aluControlQ;
  logic       branchQ;
  logic       aluSrcQ;
  logic [1:0] flagWriteQ;
  logic [3:0] condQ;
  logic [3:0] flagsQ;
  logic       condEx;

  logic flagN, flagZ, flagC, flagV;
  assign {flagN, flagZ, flagC, flagV} = flagsQ;

  always_comb begin
    condEx = 1'b0;
    case (condQ)
      4'b0000: condEx = flagZ;
      4'b0001: condEx = ~flagZ;
      4'b0010: condEx = flagC;
      4'b0011: condEx = ~flagC;
      4'b0100: condEx = flagN;
      4'b0101: condEx = ~flagN;
      4'b0110: condEx = flagV;
      4'b0111: condEx = ~flagV;
      4'b1000: condEx = flagC & ~flagZ;
      4'b1001: condEx = ~flagC | flagZ;
      4'b1010: condEx = (flagN == flagV);
      4'b1011: condEx = (flagN != flagV);
      4'b1100: condEx = ~flagZ & (flagN == flagV);
      4'b1101: condEx = flagZ | (flagN != flagV);
      4'b1110: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

  // Flags follow the instruction already in E, so a same-edge flush does not cancel them,
  // while a stall blocks them so a held instruction is applied only once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pcSrcQ      <= 1'b0;
      regWriteQ   <= 1'b0;
      memtoRegQ   <= 1'b0;
      memWriteQ   <= 1'b0;
      aluControlQ <= 4'b0000;
      branchQ     <= 1'b0;
      aluSrcQ     <= 1'b0;
      flagWriteQ  <= 2'b00;
      condQ       <= 4'b0000;
      flagsQ      <= FLAGS_RESET;
    end else begin
      if (!StallE) begin
        if (flagWriteQ[1] && condEx) flagsQ[3:2] <= ALUFlagsE[3:2];
        if (flagWriteQ[0] && condEx) flagsQ[1:0] <= ALUFlagsE[1:0];
      end
      if (FlushE) begin
        pcSrcQ      <= 1'b0;
        regWriteQ   <= 1'b0;
        memtoRegQ   <= 1'b0;
        memWriteQ   <= 1'b0;
        aluControlQ <= 4'b0000;
        branchQ     <= 1'b0;
        aluSrcQ     <= 1'b0;
        flagWriteQ  <= 2'b00;
        condQ       <= 4'b0000;
      end else if (!StallE) begin
        pcSrcQ      <= PCSrcD;
        regWriteQ   <= RegWriteD;
        memtoRegQ   <= MemtoRegD;
        memWriteQ   <= MemWriteD;
        aluControlQ <= ALUControlD;
        branchQ     <= BranchD;
        aluSrcQ     <= ALUSrcD;
        flagWriteQ  <= FlagWriteD;
        condQ       <= CondD;
      end
    end
  end

  assign CondExE      = condEx;
  assign PCSrcE       = pcSrcQ & condEx;
  assign RegWriteE    = regWriteQ & condEx;
  assign MemWriteE    = memWriteQ & condEx;
  assign BranchTakenE = branchQ & condEx;
  assign MemtoRegE    = memtoRegQ;
  assign ALUControlE  = aluControlQ;
  assign ALUSrcE      = aluSrcQ;
  assign FlagsE       = flagsQ;

endmodule
